// File: rtl/parking_stay_scheduler.sv
// parking_stay_scheduler
//
// Purpose:
//   Shares one free-running parking timer between NUM_SLOTS bays. Each bay
//   timestamps the timer on entry and computes its stay duration on exit.
//   Completed stays are queued per bay and handed out one at a time over a
//   valid/ready port, chosen round-robin. Stays of 2^TW ticks or more are
//   flagged as long and their duration saturates to 2^TW-1.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset (sampled on clk rising edge)
//   timer_count  shared timer, advances by at most 1 per cycle, wraps
//   entry_pulse  per-bay one-cycle pulse: car entered
//   exit_pulse   per-bay one-cycle pulse: car left
//   occupied     per-bay: bay currently holds a car
//   out_valid    a completed stay is being presented
//   out_ready    consumer accepts the presented stay
//   out_slot     bay index of the presented stay
//   out_elapsed  stay duration in timer ticks (saturated when long)
//   out_long     stay reached or exceeded 2^TW ticks
//   err          one-cycle pulse when any illegal event was seen last cycle

module parking_stay_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int TW        = 10,
    parameter int SW        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TW-1:0]        timer_count,
    input  logic [NUM_SLOTS-1:0] entry_pulse,
    input  logic [NUM_SLOTS-1:0] exit_pulse,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_slot,
    output logic [TW-1:0]        out_elapsed,
    output logic                 out_long,
    output logic                 err
);

    typedef enum logic {
        SLOT_IDLE     = 1'b0,
        SLOT_OCCUPIED = 1'b1
    } slotState_t;

    // Per-bay state
    slotState_t           r_slotState     [NUM_SLOTS];
    slotState_t           w_slotStateNext [NUM_SLOTS];
    logic [TW-1:0]        r_start         [NUM_SLOTS];
    logic [TW-1:0]        r_dur           [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_pending;
    logic [NUM_SLOTS-1:0] r_long;
    logic [NUM_SLOTS-1:0] r_durLong;

    // Shared state
    logic [TW-1:0]        r_prevTimer;
    logic [SW-1:0]        r_rrPtr;
    logic                 r_outValid;
    logic [SW-1:0]        r_outSlot;
    logic [TW-1:0]        r_outElapsed;
    logic                 r_outLong;
    logic                 r_err;

    // Event classification and arbitration
    logic [NUM_SLOTS-1:0] w_entryOk;
    logic [NUM_SLOTS-1:0] w_exitOk;
    logic [NUM_SLOTS-1:0] w_illegal;
    logic [NUM_SLOTS-1:0] w_wrapHit;
    logic [NUM_SLOTS-1:0] w_grantMask;
    logic                 w_outFree;
    logic                 w_grantFound;
    logic [SW-1:0]        w_grantIdx;
    logic [SW-1:0]        w_rrNext;

    // Classify this cycle's pulses against each bay's current state.
    // An idle bay can only accept an entry, so a simultaneous exit is the
    // illegal half; an occupied bay can only accept an exit, so a
    // simultaneous entry is the illegal half. An exit is refused while the
    // previous result of that bay is still waiting to be delivered.
    // The wrap hit fires on the exact tick the timer returns to the entry
    // timestamp, i.e. after a full 2^TW ticks of stay.
    always_comb begin
        w_entryOk = '0;
        w_exitOk  = '0;
        w_illegal = '0;
        w_wrapHit = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slotState[i] == SLOT_IDLE) begin
                w_entryOk[i] = entry_pulse[i];
                w_illegal[i] = exit_pulse[i];
            end else begin
                w_wrapHit[i] = (timer_count == r_start[i]) &&
                               (r_prevTimer == r_start[i] - TW'(1));
                w_exitOk[i]  = exit_pulse[i] && !r_pending[i];
                w_illegal[i] = entry_pulse[i] || (exit_pulse[i] && r_pending[i]);
            end
        end
    end

    // Bay FSM: state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!reset) begin
                r_slotState[i] <= SLOT_IDLE;
            end else begin
                r_slotState[i] <= w_slotStateNext[i];
            end
        end
    end

    // Bay FSM: next-state logic.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_slotStateNext[i] = r_slotState[i];
            case (r_slotState[i])
                SLOT_IDLE: begin
                    if (w_entryOk[i]) begin
                        w_slotStateNext[i] = SLOT_OCCUPIED;
                    end
                end
                SLOT_OCCUPIED: begin
                    if (w_exitOk[i]) begin
                        w_slotStateNext[i] = SLOT_IDLE;
                    end
                end
                default: begin
                    w_slotStateNext[i] = SLOT_IDLE;
                end
            endcase
        end
    end

    // Bay FSM: outputs.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occupied[i] = (r_slotState[i] == SLOT_OCCUPIED);
        end
    end

    // Round-robin pick among bays with a pending result, starting at the
    // pointer. Only searched when the output register can be reloaded,
    // which also covers the handshake cycle so results flow back to back.
    always_comb begin : arbiterSearch
        int idx;
        idx          = 0;
        w_outFree    = !r_outValid || out_ready;
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_grantMask  = '0;
        w_rrNext     = r_rrPtr;
        if (w_outFree) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                idx = (int'(r_rrPtr) + k) % NUM_SLOTS;
                if (!w_grantFound && r_pending[idx]) begin
                    w_grantFound     = 1'b1;
                    w_grantIdx       = SW'(idx);
                    w_grantMask[idx] = 1'b1;
                    w_rrNext         = SW'((idx + 1) % NUM_SLOTS);
                end
            end
        end
    end

    // Timestamps, durations, pending queue and the output register.
    // The long flag of a finished stay is copied into r_durLong at exit so
    // that a re-entry (which clears r_long) cannot corrupt a result that is
    // still waiting to be delivered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prevTimer  <= '0;
            r_rrPtr      <= '0;
            r_outValid   <= 1'b0;
            r_outSlot    <= '0;
            r_outElapsed <= '0;
            r_outLong    <= 1'b0;
            r_err        <= 1'b0;
            r_pending    <= '0;
            r_long       <= '0;
            r_durLong    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_start[i] <= '0;
                r_dur[i]   <= '0;
            end
        end else begin
            r_prevTimer <= timer_count;
            r_err       <= |w_illegal;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_entryOk[i]) begin
                    r_start[i] <= timer_count;
                    r_long[i]  <= 1'b0;
                end else if (w_wrapHit[i]) begin
                    r_long[i]  <= 1'b1;
                end
                if (w_exitOk[i]) begin
                    if (r_long[i] || w_wrapHit[i]) begin
                        r_dur[i]     <= '1;
                        r_durLong[i] <= 1'b1;
                    end else begin
                        r_dur[i]     <= timer_count - r_start[i];
                        r_durLong[i] <= 1'b0;
                    end
                end
            end
            // A granted bay had pending=1, an exiting bay had pending=0,
            // so the clear and the set never hit the same bit.
            r_pending <= (r_pending & ~w_grantMask) | w_exitOk;
            if (w_outFree) begin
                if (w_grantFound) begin
                    r_outValid   <= 1'b1;
                    r_outSlot    <= w_grantIdx;
                    r_outElapsed <= r_dur[w_grantIdx];
                    r_outLong    <= r_durLong[w_grantIdx];
                    r_rrPtr      <= w_rrNext;
                end else begin
                    r_outValid   <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = r_outValid;
    assign out_slot    = r_outSlot;
    assign out_elapsed = r_outElapsed;
    assign out_long    = r_outLong;
    assign err         = r_err;

endmodule

// File: tb/tb_parking_stay_scheduler.sv
// tb_parking_stay_scheduler
//
// Purpose:
//   Drives parking_stay_scheduler with directed scenarios followed by
//   randomized traffic and compares every cycle against a behavioural
//   model. The model measures a stay by counting timer advances since
//   entry (a stay is long once 2^TW advances have been counted) and
//   keeps per-bay result slots plus a round-robin pointer.
//
// Ports: none (top-level bench).

`timescale 1ns/1ps

module tb_parking_stay_scheduler;

    localparam int NUM_SLOTS = 4;
    localparam int TW        = 10;
    localparam int SW        = 2;
    localparam int FULL      = 1 << TW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [TW-1:0]        timer_count;
    logic [NUM_SLOTS-1:0] entry_pulse;
    logic [NUM_SLOTS-1:0] exit_pulse;
    logic [NUM_SLOTS-1:0] occupied;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_slot;
    logic [TW-1:0]        out_elapsed;
    logic                 out_long;
    logic                 err;

    always #5 clk = ~clk;

    parking_stay_scheduler #(
        .NUM_SLOTS(NUM_SLOTS),
        .TW(TW),
        .SW(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .timer_count(timer_count),
        .entry_pulse(entry_pulse),
        .exit_pulse(exit_pulse),
        .occupied(occupied),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_slot(out_slot),
        .out_elapsed(out_elapsed),
        .out_long(out_long),
        .err(err)
    );

    int checkCount = 0;
    int errorCount = 0;
    int tmr = 0;

    // Behavioural model state
    bit mOcc     [NUM_SLOTS];
    int mTicks   [NUM_SLOTS];
    bit mPend    [NUM_SLOTS];
    int mDur     [NUM_SLOTS];
    bit mDurLong [NUM_SLOTS];
    bit mValid;
    int mSlot;
    int mElapsed;
    bit mLong;
    bit mErr;
    int mRr;
    int lastTimer;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelOcc();
        int v;
        v = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (mOcc[i]) v = v | (1 << i);
        end
        return v;
    endfunction

    // One clock edge of the reference behaviour.
    function automatic void modelStep(input logic [NUM_SLOTS-1:0] en, input logic [NUM_SLOTS-1:0] ex,
                                      input bit rdy, input bit rstN, input int timerVal);
        bit oldPend [NUM_SLOTS];
        bit free;
        int g;
        if (!rstN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mOcc[i] = 0; mTicks[i] = 0; mPend[i] = 0; mDur[i] = 0; mDurLong[i] = 0;
            end
            mValid = 0; mSlot = 0; mElapsed = 0; mLong = 0; mErr = 0; mRr = 0;
            lastTimer = timerVal;
            return;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (mOcc[i] && timerVal != lastTimer && mTicks[i] < FULL) mTicks[i]++;
        end
        oldPend = mPend;
        free = !mValid || rdy;
        g = -1;
        if (free) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (g < 0 && oldPend[(mRr + k) % NUM_SLOTS]) g = (mRr + k) % NUM_SLOTS;
            end
        end
        mErr = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!mOcc[i]) begin
                if (en[i]) begin
                    mOcc[i] = 1;
                    mTicks[i] = 0;
                end
                if (ex[i]) mErr = 1;
            end else begin
                if (en[i]) mErr = 1;
                if (ex[i]) begin
                    if (oldPend[i]) begin
                        mErr = 1;
                    end else begin
                        mOcc[i] = 0;
                        mDurLong[i] = (mTicks[i] >= FULL);
                        mDur[i] = mDurLong[i] ? FULL - 1 : mTicks[i];
                        mPend[i] = 1;
                    end
                end
            end
        end
        if (free) begin
            if (g >= 0) begin
                mValid = 1;
                mSlot = g;
                mElapsed = mDur[g];
                mLong = mDurLong[g];
                mPend[g] = 0;
                mRr = (g + 1) % NUM_SLOTS;
            end else begin
                mValid = 0;
            end
        end
        lastTimer = timerVal;
    endfunction

    // Drive one cycle at the falling edge, step the model, then compare
    // just after the rising edge.
    task automatic applyStimulus(input logic [NUM_SLOTS-1:0] en, input logic [NUM_SLOTS-1:0] ex,
                                 input bit rdy, input bit rstN, input bit adv);
        if (adv) tmr = (tmr + 1) % FULL;
        timer_count = TW'(tmr);
        entry_pulse = en;
        exit_pulse  = ex;
        out_ready   = rdy;
        reset       = rstN;
        modelStep(en, ex, rdy, rstN, tmr);
        @(posedge clk);
        #1;
        checkOutput("occupied", int'(occupied), modelOcc());
        checkOutput("out_valid", int'(out_valid), int'(mValid));
        checkOutput("err", int'(err), int'(mErr));
        if (mValid) begin
            checkOutput("out_slot", int'(out_slot), mSlot);
            checkOutput("out_elapsed", int'(out_elapsed), mElapsed);
            checkOutput("out_long", int'(out_long), int'(mLong));
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) applyStimulus('0, '0, rdy, 1'b1, 1'b1);
    endtask

    initial begin
        logic [NUM_SLOTS-1:0] rEn;
        logic [NUM_SLOTS-1:0] rEx;

        // Reset state
        tmr = 0;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("resetOccupied", int'(occupied), 0);
        checkOutput("resetValid", int'(out_valid), 0);
        checkOutput("resetErr", int'(err), 0);

        // Basic stay: slot 1 from 100 to 350
        tmr = 99;
        applyStimulus(4'b0010, '0, 1'b1, 1'b1, 1'b1);
        idle(249, 1'b1);
        applyStimulus('0, 4'b0010, 1'b1, 1'b1, 1'b1);
        checkOutput("basicOccAfterExit", int'(occupied[1]), 0);
        checkOutput("basicNotYetValid", int'(out_valid), 0);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("basicValid", int'(out_valid), 1);
        checkOutput("basicSlot", int'(out_slot), 1);
        checkOutput("basicElapsed", int'(out_elapsed), 250);
        checkOutput("basicLong", int'(out_long), 0);
        idle(2, 1'b1);

        // Wrap: slot 0 from 1000 to 40
        tmr = 999;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001, '0, 1'b1, 1'b1, 1'b1);
        idle(63, 1'b1);
        applyStimulus('0, 4'b0001, 1'b1, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("wrapSlot", int'(out_slot), 0);
        checkOutput("wrapElapsed", int'(out_elapsed), 64);
        checkOutput("wrapLong", int'(out_long), 0);
        idle(2, 1'b1);

        // Long stay: slot 2, 1030 ticks
        tmr = 4;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, '0, 1'b1, 1'b1, 1'b1);
        idle(1029, 1'b1);
        applyStimulus('0, 4'b0100, 1'b1, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("longSlot", int'(out_slot), 2);
        checkOutput("longElapsed", int'(out_elapsed), 1023);
        checkOutput("longFlag", int'(out_long), 1);
        idle(2, 1'b1);

        // Arbitration under backpressure
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1111, '0, 1'b0, 1'b1, 1'b1);
        idle(10, 1'b0);
        applyStimulus('0, 4'b1101, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
            checkOutput("holdValid", int'(out_valid), 1);
            checkOutput("holdSlot", int'(out_slot), 0);
            checkOutput("holdElapsed", int'(out_elapsed), 11);
        end
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("rrSecond", int'(out_slot), 2);
        applyStimulus('0, 4'b0010, 1'b1, 1'b1, 1'b1);
        checkOutput("rrThird", int'(out_slot), 3);
        checkOutput("rrThirdValid", int'(out_valid), 1);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("rrFourth", int'(out_slot), 1);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("rrDrained", int'(out_valid), 0);

        // Illegal events
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1000, '0, 1'b1, 1'b1, 1'b1);
        idle(5, 1'b1);
        applyStimulus(4'b1000, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("errEntryOccupied", int'(err), 1);
        idle(3, 1'b1);
        checkOutput("errPulseOneCycle", int'(err), 0);
        applyStimulus('0, 4'b1000, 1'b1, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("errStartKept", int'(out_elapsed), 10);
        applyStimulus('0, 4'b0001, 1'b1, 1'b1, 1'b1);
        checkOutput("errExitIdle", int'(err), 1);
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("errExitIdleNoResult", int'(out_valid), 0);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1);
        checkOutput("errBothIdleOcc", int'(occupied[1]), 1);
        checkOutput("errBothIdleErr", int'(err), 1);
        idle(2, 1'b1);

        // Reset mid-operation
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0011, '0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b0);
        applyStimulus(4'b0100, 4'b0001, 1'b0, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("midHeldValid", int'(out_valid), 1);
        checkOutput("midOccupied", int'(occupied), 6);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("midResetOcc", int'(occupied), 0);
        checkOutput("midResetValid", int'(out_valid), 0);
        for (int n = 0; n < 5; n++) begin
            applyStimulus('0, '0, 1'b1, 1'b1, 1'b1);
            checkOutput("midNoStale", int'(out_valid), 0);
        end

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NUM_SLOTS; b++) begin
                rEn[b] = ($urandom_range(0, 5) == 0);
                rEx[b] = ($urandom_range(0, 5) == 0);
            end
            applyStimulus(rEn, rEx, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 299) != 0), ($urandom_range(0, 4) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
